// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two combinational read ports, optional
// hardwired-zero R0 and write bypass, a pending-load scoreboard and a sequential clear engine.
module regfile_param #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [DW-1:0] wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          mark_en,
  input  logic [AW-1:0] mark_addr,
  output logic          rdy1,
  output logic          rdy2,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0] PTR_FIRST = (ZERO_R0 != 0) ? AW'(1'b1) : {AW{1'b0}};
  localparam logic [AW-1:0] PTR_LAST  = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } clr_state_t;

  logic [DW-1:0] regs_r [N];
  logic [N-1:0]  pend_r;
  logic [AW-1:0] ptr_r;
  clr_state_t    state_r;
  clr_state_t    state_s;
  logic          clr_busy_r;
  logic          clr_done_r;
  logic          wr_ok_s;
  logic          mark_ok_s;
  logic          clr_start_s;

  function automatic logic is_r0(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == {AW{1'b0}});
  endfunction

  // A write in flight that a read port at address a should see this cycle
  function automatic logic byp_hit(input logic [AW-1:0] a);
    return (BYPASS != 0) && we3 && !clr_busy_r && (wa3 == a) && !is_r0(a);
  endfunction

  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;

  // Qualify write, mark and sweep-start requests
  always_comb begin
    wr_ok_s     = we3 && !clr_busy_r && !is_r0(wa3);
    mark_ok_s   = mark_en && !clr_busy_r && !is_r0(mark_addr);
    clr_start_s = (state_r == IDLE) && clr_req;
  end

  // Clear engine next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_s = SWEEP;
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        if (ptr_r == PTR_LAST) begin
          state_s = DONE;
        end else begin
          state_s = SWEEP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Clear engine state, sweep pointer and registered status decodes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      ptr_r      <= {AW{1'b0}};
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      clr_busy_r <= (state_s == SWEEP);
      clr_done_r <= (state_s == DONE);
      if (clr_start_s) begin
        ptr_r <= PTR_FIRST;
      end else if ((state_r == SWEEP) && (ptr_r != PTR_LAST)) begin
        ptr_r <= ptr_r + AW'(1'b1);
      end
    end
  end

  // Register storage: the sweep owns the array while it runs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (state_r == SWEEP) begin
      regs_r[ptr_r] <= {DW{1'b0}};
    end else if (wr_ok_s) begin
      regs_r[wa3] <= wd3;
    end
  end

  // Pending-load scoreboard; a mark issued alongside a write to the same register wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_r <= {N{1'b0}};
    end else if (clr_start_s) begin
      pend_r <= {N{1'b0}};
    end else begin
      if (wr_ok_s) begin
        pend_r[wa3] <= 1'b0;
      end
      if (mark_ok_s) begin
        pend_r[mark_addr] <= 1'b1;
      end
    end
  end

  // Read ports and operand-ready flags
  always_comb begin
    rd1  = regs_r[ra1];
    rdy1 = ~pend_r[ra1];
    if (is_r0(ra1)) begin
      rd1  = {DW{1'b0}};
      rdy1 = 1'b1;
    end else if (byp_hit(ra1)) begin
      rd1  = wd3;
      rdy1 = 1'b1;
    end else begin
      rd1  = regs_r[ra1];
      rdy1 = ~pend_r[ra1];
    end

    rd2  = regs_r[ra2];
    rdy2 = ~pend_r[ra2];
    if (is_r0(ra2)) begin
      rd2  = {DW{1'b0}};
      rdy2 = 1'b1;
    end else if (byp_hit(ra2)) begin
      rd2  = wd3;
      rdy2 = 1'b1;
    end else begin
      rd2  = regs_r[ra2];
      rdy2 = ~pend_r[ra2];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance (ZERO_R0=1, BYPASS=1) and a plain one
// (ZERO_R0=0, BYPASS=0) share stimulus and are checked against a set-based reference model.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we3 = 1'b0;
  logic [2:0] wa3 = 3'd0;
  logic [7:0] wd3 = 8'h00;
  logic [2:0] ra1 = 3'd0;
  logic [2:0] ra2 = 3'd0;
  logic       mark_en = 1'b0;
  logic [2:0] mark_addr = 3'd0;
  logic       clr_req = 1'b0;

  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic       rdy1_a, rdy2_a, rdy1_b, rdy2_b;
  logic       busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  regfile_param #(.DW(8), .AW(3), .ZERO_R0(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_a), .rd2(rd2_a), .mark_en(mark_en), .mark_addr(mark_addr),
    .rdy1(rdy1_a), .rdy2(rdy2_a), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
  );

  regfile_param #(.DW(8), .AW(3), .ZERO_R0(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_b), .rd2(rd2_b), .mark_en(mark_en), .mark_addr(mark_addr),
    .rdy1(rdy1_b), .rdy2(rdy2_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: instance 0 has zero R0 and bypass, instance 1 has neither.
  // to_clear holds the set of registers the sweep still has to zero, lowest first.
  logic [7:0] mreg [2][8];
  logic [7:0] mpend [2];
  logic [7:0] to_clear [2];
  bit         mdone [2];
  bit         m_start;
  bit         chk_on = 1'b0;

  function automatic logic [7:0] exp_rd(input int k, input logic [2:0] a);
    if (k == 0 && a == 3'd0) return 8'h00;
    if (k == 0 && we3 && to_clear[k] == 8'h00 && wa3 == a) return wd3;
    return mreg[k][a];
  endfunction

  function automatic logic exp_rdy(input int k, input logic [2:0] a);
    if (k == 0 && a == 3'd0) return 1'b1;
    if (k == 0 && we3 && to_clear[k] == 8'h00 && wa3 == a) return 1'b1;
    return ~mpend[k][a];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int i = 0; i < 8; i++) mreg[k][i] = 8'h00;
        mpend[k] = 8'h00;
        to_clear[k] = 8'h00;
        mdone[k] = 1'b0;
      end else if (to_clear[k] != 8'h00) begin
        for (int i = 0; i < 8; i++) begin
          if (to_clear[k][i]) begin
            mreg[k][i] = 8'h00;
            to_clear[k][i] = 1'b0;
            break;
          end
        end
        if (to_clear[k] == 8'h00) mdone[k] = 1'b1;
      end else begin
        m_start = clr_req && !mdone[k];
        mdone[k] = 1'b0;
        if (we3 && !(k == 0 && wa3 == 3'd0)) begin
          mreg[k][wa3] = wd3;
          mpend[k][wa3] = 1'b0;
        end
        if (mark_en && !(k == 0 && mark_addr == 3'd0)) mpend[k][mark_addr] = 1'b1;
        if (m_start) begin
          mpend[k] = 8'h00;
          to_clear[k] = (k == 0) ? 8'hFE : 8'hFF;
        end
      end
    end
  end

  // Every cycle, all outputs of both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check8("m_rd1_a", rd1_a, exp_rd(0, ra1));
      check8("m_rd2_a", rd2_a, exp_rd(0, ra2));
      check1("m_rdy1_a", rdy1_a, exp_rdy(0, ra1));
      check1("m_rdy2_a", rdy2_a, exp_rdy(0, ra2));
      check1("m_busy_a", busy_a, to_clear[0] != 8'h00);
      check1("m_done_a", done_a, mdone[0]);
      check8("m_rd1_b", rd1_b, exp_rd(1, ra1));
      check8("m_rd2_b", rd2_b, exp_rd(1, ra2));
      check1("m_rdy1_b", rdy1_b, exp_rdy(1, ra1));
      check1("m_rdy2_b", rdy2_b, exp_rdy(1, ra2));
      check1("m_busy_b", busy_b, to_clear[1] != 8'h00);
      check1("m_done_b", done_b, mdone[1]);
    end
  end

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       mk;
    logic [2:0] ma;
    logic [7:0] e_rd1;
    logic [7:0] e_rd2;
    logic       e_rdy1;
    logic       e_rdy2;
    logic [7:0] e_rd1b;
  } vec_t;

  vec_t vt [12];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all();
    for (int a = 0; a < 8; a++) begin
      next_cycle();
      we3 = 1'b1;
      wa3 = 3'(a);
      wd3 = 8'h80 | 8'(a);
      mark_en = 1'b0;
    end
    next_cycle();
    we3 = 1'b0;
  endtask

  task automatic expect_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      next_cycle();
      we3 = 1'b0;
      mark_en = 1'b0;
      ra1 = 3'(a);
      ra2 = 3'(a);
      @(negedge clk);
      check8({tag, "_rd_a"}, rd1_a, 8'h00);
      check8({tag, "_rd_b"}, rd1_b, 8'h00);
      check1({tag, "_rdy_a"}, rdy1_a, 1'b1);
      check1({tag, "_rdy_b"}, rdy1_b, 1'b1);
    end
  endtask

  int ba, da, bb, db;

  initial begin
    //        we    wa    wd     r1    r2    mk    ma    rd1    rd2    rdy1  rdy2  rd1b
    vt[0]  = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd5, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h00};
    vt[1]  = '{1'b1, 3'd5, 8'h3C, 3'd3, 3'd5, 1'b0, 3'd0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5};
    vt[2]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd5, 1'b0, 3'd0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5};
    vt[3]  = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 1'b0, 3'd0, 8'h00, 8'hA5, 1'b1, 1'b1, 8'h00};
    vt[4]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 1'b0, 3'd0, 8'h00, 8'h3C, 1'b1, 1'b1, 8'hFF};
    vt[5]  = '{1'b1, 3'd2, 8'h77, 3'd2, 3'd0, 1'b0, 3'd0, 8'h77, 8'h00, 1'b1, 1'b1, 8'h00};
    vt[6]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 1'b1, 3'd4, 8'h00, 8'h77, 1'b1, 1'b1, 8'h00};
    vt[7]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 1'b0, 3'd0, 8'h00, 8'h77, 1'b0, 1'b1, 8'h00};
    vt[8]  = '{1'b1, 3'd4, 8'h11, 3'd4, 3'd2, 1'b0, 3'd0, 8'h11, 8'h77, 1'b1, 1'b1, 8'h00};
    vt[9]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd6, 1'b0, 3'd0, 8'h11, 8'h00, 1'b1, 1'b1, 8'h11};
    vt[10] = '{1'b1, 3'd6, 8'h5A, 3'd6, 3'd4, 1'b1, 3'd6, 8'h5A, 8'h11, 1'b1, 1'b1, 8'h00};
    vt[11] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd0, 1'b0, 3'd0, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A};

    // Reset state
    next_cycle();
    chk_on = 1'b1;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check1("reset_busy", busy_a, 1'b0);
    check1("reset_done", done_a, 1'b0);
    check8("reset_rd_b", rd1_b, 8'h00);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      we3 = vt[i].we; wa3 = vt[i].wa; wd3 = vt[i].wd;
      ra1 = vt[i].r1; ra2 = vt[i].r2;
      mark_en = vt[i].mk; mark_addr = vt[i].ma;
      @(negedge clk);
      check8($sformatf("v%0d_rd1", i), rd1_a, vt[i].e_rd1);
      check8($sformatf("v%0d_rd2", i), rd2_a, vt[i].e_rd2);
      check1($sformatf("v%0d_rdy1", i), rdy1_a, vt[i].e_rdy1);
      check1($sformatf("v%0d_rdy2", i), rdy2_a, vt[i].e_rdy2);
      check8($sformatf("v%0d_rd1b", i), rd1_b, vt[i].e_rd1b);
    end

    // Full sweep with a dropped write and mark in its third cycle
    fill_all();
    clr_req = 1'b1;
    ba = 0; da = 0; bb = 0; db = 0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      clr_req = 1'b0;
      we3 = (i == 2); wa3 = 3'd1; wd3 = 8'hEE;
      mark_en = (i == 2); mark_addr = 3'd5;
      @(negedge clk);
      if (busy_a) ba++;
      if (done_a) da++;
      if (busy_b) bb++;
      if (done_b) db++;
      if (i == 7) check1("sweep_done_a_t8", done_a, 1'b1);
    end
    checkn("sweep_busy_cycles_a", ba, 7);
    checkn("sweep_done_cycles_a", da, 1);
    checkn("sweep_busy_cycles_b", bb, 8);
    checkn("sweep_done_cycles_b", db, 1);
    expect_all_zero("after_sweep");

    // Reset in the third sweep cycle
    fill_all();
    mark_en = 1'b1; mark_addr = 3'd2;
    next_cycle();
    mark_en = 1'b0;
    clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clr_req = 1'b0;
      if (i == 2) rst = 1'b0;
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check1("rst_mid_busy_a", busy_a, 1'b0);
    check1("rst_mid_done_a", done_a, 1'b0);
    check1("rst_mid_busy_b", busy_b, 1'b0);
    check1("rst_mid_done_b", done_b, 1'b0);
    expect_all_zero("after_rst");

    // Randomised traffic checked by the model
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      rst       = ($urandom_range(199, 0) != 0);
      we3       = 1'($urandom);
      wa3       = 3'($urandom);
      wd3       = 8'($urandom);
      ra1       = 3'($urandom);
      ra2       = ($urandom_range(3, 0) == 0) ? wa3 : 3'($urandom);
      mark_en   = ($urandom_range(3, 0) == 0);
      mark_addr = ($urandom_range(3, 0) == 0) ? wa3 : 3'($urandom);
      clr_req   = ($urandom_range(39, 0) == 0);
    end
    next_cycle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the datapath: one write port, two combinational read ports, a configurable hardwired-zero R0 and optional write-to-read bypass. A per-register pending scoreboard tracks outstanding loads for the issue stage. A sequential clear engine lets the controller zero the file without asserting reset.

## Interface
- DW, 8, data width in bits
- AW, 3, address width; depth N = 2^AW
- ZERO_R0, 1, when 1, R0 reads 0 always and ignores writes
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- we3  in  1  write enable
- wa3  in  AW  write address
- wd3  in  DW  write data
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  DW  read data, combinational
- mark_en  in  1  set pending bit of mark_addr (load issued)
- mark_addr  in  AW  register receiving outstanding load
- rdy1, rdy2  out  1  operand at ra1/ra2 not pending
- clr_req  in  1  start clear sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse, sweep finished

## Operation
- Reset (rst=0 at edge): all N registers to 0; all pending bits to 0; FSM to IDLE; clr_busy=0, clr_done=0. Reset overrides every other input, including mid-sweep.
- Write: at edge, if we3=1 and clr_busy=0 and not (ZERO_R0=1 and wa3=0), reg[wa3] <= wd3 and pend[wa3] <= 0.
- Read: rd1 = reg[ra1], rd2 = reg[ra2]. If ZERO_R0=1 and address is 0, output 0. If BYPASS=1, we3=1, clr_busy=0 and wa3 equals the read address (nonzero when ZERO_R0=1), output wd3.
- Scoreboard: at edge, if mark_en=1 and clr_busy=0 and not (ZERO_R0=1 and mark_addr=0), pend[mark_addr] <= 1. A mark and a write to the same address in the same cycle leaves pend=1, because the mark wins. Register data is still written.
- rdyN = ~pend[raN]. With BYPASS=1, rdyN is also 1 when a qualifying write to raN occurs in the same cycle. R0 is always ready when ZERO_R0=1.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on clr_req=1. On entry, ptr <= (ZERO_R0 ? 1 : 0) and all pend bits <= 0.
  - SWEEP: each cycle reg[ptr] <= 0, ptr++. After ptr = N-1 is written, go to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
- While clr_busy=1: we3 and mark_en are ignored (dropped, not queued), and clr_req is ignored. clr_req in DONE is also ignored.
- ptr is AW bits wide; the terminal compare is on N-1, so ptr never wraps.

## Timing
- Write latency: data is visible on rd one cycle after the edge. With BYPASS=1 it is visible combinationally in the same cycle.
- Pending set/clear takes effect on rdy the cycle after the edge.
- clr_req sampled at edge T gives clr_busy=1 from T+1. With defaults (ZERO_R0=1, N=8), SWEEP lasts 7 cycles, clearing R1..R7 at edges T+1..T+7. DONE (clr_done=1, clr_busy=0) occupies T+8, and IDLE follows at T+9.
- With ZERO_R0=0, SWEEP lasts N cycles.
- clr_busy is a registered state decode; clr_done is high only in DONE.
- Bypass and rdy paths are combinational from we3/wa3/wd3/ra.

## Test plan
- Reset, then write R3=0xA5 and R5=0x3C. Read ra1=3, ra2=5 next cycle -> rd1=0xA5, rd2=0x3C.
- Write wa3=0, wd3=0xFF with ZERO_R0=1 -> rd1 at ra1=0 stays 0x00. With ZERO_R0=0 -> rd1=0xFF.
- BYPASS=1: we3=1, wa3=2, wd3=0x77, ra1=2 in the same cycle -> rd1=0x77 and rdy1=1 combinationally. BYPASS=0 -> rd1 shows the old value.
- Scoreboard: mark R4 -> rdy1=0 at ra1=4 next cycle. Write R4=0x11 -> rdy1=1 next cycle and rd1=0x11. Mark and write R6 in the same cycle -> rdy=0 for R6.
- Fill R1..R7 with nonzero data, pulse clr_req -> clr_busy high for 7 cycles, then clr_done for 1 cycle, then all reads return 0. A we3 issued during the sweep is not stored.
- Assert rst=0 at the third sweep cycle -> next cycle clr_busy=0, clr_done=0, all registers 0, all rdy=1.
